instr_fetch: RTL and testbench

Synchronous instruction fetch unit sitting directly upstream of the LAB4 processor. It replaces the DONE-clocked address counter and memory pair. The block owns the program counter and a 32×9 instruction ROM, and presents each instruction on D_IN with a one-cycle RUN pulse. It waits for the processor's DONE, supplies the immediate word for MVI, advances the PC, and halts or wraps at end of program. All logic runs on the single system clock.

---
 rtl/instr_fetch_pkg.sv | 22 ++
 rtl/instr_fetch_if.sv | 15 +
 rtl/instr_fetch_rom.sv | 27 ++
 rtl/instr_fetch.sv | 134 +++++++++++++
 tb/tb_instr_fetch.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 9;

  // Opcode field position within an instruction word
  localparam int OP_HI = 8;
  localparam int OP_LO = 6;

  localparam logic [2:0] MVI_OP = 3'b001;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_HALT,
    S_ERR
  } state_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Issue handshake between the fetch unit (master) and the processor (slave).
interface instr_fetch_if
  import fetch_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);

  logic [DATA_W-1:0] D_IN;
  logic              RUN;
  logic              DONE;

  modport master (output D_IN, output RUN, input DONE);
  modport slave  (input D_IN, input RUN, output DONE);

endinterface

// File: rtl/instr_fetch_rom.sv
// Synchronous-read program ROM, one cycle read latency.
// Contents come from the flattened ROM_INIT image (word i at bits i*DATA_W).
module instr_rom #(
  parameter int                               ADDR_W   = 5,
  parameter int                               DATA_W   = 9,
  parameter logic [DATA_W*(2**ADDR_W)-1:0]    ROM_INIT = '0
) (
  input  logic              i_clk,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] o_data
);

  logic [DATA_W-1:0] w_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_data;

  for (genvar g = 0; g < 2**ADDR_W; g++) begin : g_word
    assign w_mem[g] = ROM_INIT[g*DATA_W +: DATA_W];
  end

  // Registered read port
  always_ff @(posedge i_clk) begin
    r_data <= w_mem[i_addr];
  end

  assign o_data = r_data;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC and program ROM, issues one
// instruction per RUN strobe, waits for DONE, supplies MVI immediates.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int                               ADDR_W    = ADDR_W_DEF,
  parameter int                               DATA_W    = DATA_W_DEF,
  parameter int                               LAST_ADDR = 31,
  parameter int                               WRAP      = 1,
  parameter int                               TIMEOUT   = 64,
  parameter logic [DATA_W*(2**ADDR_W)-1:0]    ROM_INIT  = '0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic              STOP,
  input  logic              PC_LOAD,
  input  logic [ADDR_W-1:0] PC_IN,
  output logic [ADDR_W-1:0] PC,
  output logic              BUSY,
  output logic              HALTED,
  output logic              ERROR,
  instr_fetch_if.master     bus
);

  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_pc;
  logic [DATA_W-1:0] r_ir;
  logic              r_stop;
  logic [WD_W-1:0]   r_wd;

  logic [DATA_W-1:0] w_rom_q;
  logic [DATA_W-1:0] w_ir_cur;
  logic [ADDR_W-1:0] w_rom_addr;
  logic [ADDR_W-1:0] w_pc_p1;
  logic [ADDR_W-1:0] w_pc_p2;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic              w_mvi;
  logic              w_hit_last;
  logic              w_busy;
  logic              w_pc_ld;
  logic              w_done_ok;

  // The ROM output register doubles as IR during ISSUE; r_ir keeps the
  // word afterwards so the ROM is free to fetch the MVI immediate.
  assign w_ir_cur   = (r_state == S_ISSUE) ? w_rom_q : r_ir;
  assign w_mvi      = (w_ir_cur[OP_HI:OP_LO] == MVI_OP);
  assign w_pc_p1    = r_pc + ADDR_W'(1);
  assign w_pc_p2    = r_pc + ADDR_W'(2);
  assign w_rom_addr = (((r_state == S_ISSUE) || (r_state == S_WAIT)) && w_mvi) ? w_pc_p1 : r_pc;
  assign w_hit_last = (r_pc == ADDR_W'(LAST_ADDR)) || (w_mvi && (w_pc_p1 == ADDR_W'(LAST_ADDR)));
  assign w_pc_nxt   = (w_hit_last && (WRAP != 0)) ? '0 : (w_mvi ? w_pc_p2 : w_pc_p1);
  assign w_busy     = (r_state == S_FETCH) || (r_state == S_ISSUE) || (r_state == S_WAIT);

  instr_rom #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .ROM_INIT (ROM_INIT)
  ) u_rom (
    .i_clk  (CLK),
    .i_addr (w_rom_addr),
    .o_data (w_rom_q)
  );

  // State register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state decode, PC load/advance strobes
  always_comb begin
    w_next    = r_state;
    w_pc_ld   = 1'b0;
    w_done_ok = 1'b0;
    case (r_state)
      S_IDLE, S_HALT: begin
        if (PC_LOAD)    w_pc_ld = 1'b1;
        else if (START) w_next  = S_FETCH;
      end
      S_FETCH: w_next = S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT: begin
        if (bus.DONE) begin
          w_done_ok = 1'b1;
          if (r_stop || STOP || (w_hit_last && (WRAP == 0))) w_next = S_HALT;
          else                                               w_next = S_FETCH;
        end else if (r_wd == WD_W'(TIMEOUT - 1)) begin
          w_next = S_ERR;
        end
      end
      S_ERR:   w_next = S_ERR;
      default: w_next = S_IDLE;
    endcase
  end

  // Program counter
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)           r_pc <= '0;
    else if (w_pc_ld)   r_pc <= PC_IN;
    else if (w_done_ok) r_pc <= w_pc_nxt;
  end

  // Instruction register, captured as the ROM word is issued
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                     r_ir <= '0;
    else if (r_state == S_ISSUE)  r_ir <= w_rom_q;
  end

  // STOP latch, consumed by the DONE that completes the current instruction
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                 r_stop <= 1'b0;
    else if (w_done_ok)       r_stop <= 1'b0;
    else if (STOP && w_busy)  r_stop <= 1'b1;
  end

  // DONE watchdog, runs only in WAIT
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                   r_wd <= '0;
    else if (r_state != S_WAIT) r_wd <= '0;
    else                        r_wd <= r_wd + WD_W'(1);
  end

  assign bus.RUN  = (r_state == S_ISSUE);
  assign bus.D_IN = ((r_state == S_WAIT) && w_mvi) ? w_rom_q : w_ir_cur;
  assign PC       = r_pc;
  assign BUSY     = w_busy;
  assign HALTED   = (r_state == S_HALT);
  assign ERROR    = (r_state == S_ERR);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: dut0 halts at end of program, dut1 wraps.
module tb_instr_fetch;

  localparam int AW = 5;
  localparam int DW = 9;
  localparam int TO = 64;

  function automatic logic [DW*32-1:0] mk_rom();
    logic [DW*32-1:0] v;
    for (int i = 0; i < 32; i++) v[i*DW +: DW] = 9'h100 + 9'(i);
    v[0*DW  +: DW] = 9'h089;
    v[1*DW  +: DW] = 9'h0D2;
    v[2*DW  +: DW] = 9'h11B;
    v[3*DW  +: DW] = 9'h1FF;
    v[4*DW  +: DW] = 9'h040;
    v[5*DW  +: DW] = 9'h0A5;
    v[6*DW  +: DW] = 9'h0C3;
    v[31*DW +: DW] = 9'h16C;
    return v;
  endfunction

  localparam logic [DW*32-1:0] ROM_IMG = mk_rom();

  logic          CLK     = 1'b0;
  logic          RST     = 1'b0;
  logic          START   = 1'b0;
  logic          STOP    = 1'b0;
  logic          PC_LOAD = 1'b0;
  logic          done    = 1'b0;
  logic [AW-1:0] PC_IN   = '0;
  logic [AW-1:0] pc0, pc1;
  logic          busy0, busy1, halt0, halt1, err0, err1;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  instr_fetch_if #(.DATA_W(DW)) bus0 ();
  instr_fetch_if #(.DATA_W(DW)) bus1 ();
  assign bus0.DONE = done;
  assign bus1.DONE = done;

  instr_fetch #(
    .ADDR_W(AW), .DATA_W(DW), .LAST_ADDR(31), .WRAP(0), .TIMEOUT(TO), .ROM_INIT(ROM_IMG)
  ) dut0 (
    .CLK(CLK), .RST(RST), .START(START), .STOP(STOP), .PC_LOAD(PC_LOAD), .PC_IN(PC_IN),
    .PC(pc0), .BUSY(busy0), .HALTED(halt0), .ERROR(err0), .bus(bus0)
  );

  instr_fetch #(
    .ADDR_W(AW), .DATA_W(DW), .LAST_ADDR(31), .WRAP(1), .TIMEOUT(TO), .ROM_INIT(ROM_IMG)
  ) dut1 (
    .CLK(CLK), .RST(RST), .START(START), .STOP(STOP), .PC_LOAD(PC_LOAD), .PC_IN(PC_IN),
    .PC(pc1), .BUSY(busy1), .HALTED(halt1), .ERROR(err1), .bus(bus1)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Leaves both DUTs in IDLE just after a clock edge ("cycle 0")
  task automatic apply_reset();
    RST = 1'b0; START = 1'b0; STOP = 1'b0; PC_LOAD = 1'b0; PC_IN = '0; done = 1'b0;
    tick();
    tick();
    RST = 1'b1;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    #3;
    total++; if (bus0.RUN !== 1'b0) begin bad++; $display("FAIL reset_run got=%b exp=0", bus0.RUN); end
    total++; if (bus0.D_IN !== 9'h000) begin bad++; $display("FAIL reset_din got=%h exp=000", bus0.D_IN); end
    total++; if (pc0 !== 5'd0) begin bad++; $display("FAIL reset_pc got=%0d exp=0", pc0); end
    total++; if ({busy0, halt0, err0} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {busy0, halt0, err0}); end
    apply_reset();
    tick();
    total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL reset_idle_busy got=%b exp=0", busy0); end
  endtask

  task automatic test_plain();
    logic          exp_run;
    logic [DW-1:0] exp_d;
    logic [AW-1:0] exp_pc;
    apply_reset();
    START = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      tick();
      done = 1'b0;
      exp_run = (c == 2) || (c == 7) || (c == 12);
      total++; if (bus0.RUN !== exp_run) begin bad++; $display("FAIL plain_run c=%0d got=%b exp=%b", c, bus0.RUN, exp_run); end
      if (exp_run || c == 3) begin
        exp_d = (c <= 3) ? 9'h089 : (c == 7) ? 9'h0D2 : 9'h11B;
        total++; if (bus0.D_IN !== exp_d) begin bad++; $display("FAIL plain_din c=%0d got=%h exp=%h", c, bus0.D_IN, exp_d); end
      end
      if (c == 6 || c == 11 || c == 16) begin
        exp_pc = (c == 6) ? 5'd1 : (c == 11) ? 5'd2 : 5'd3;
        total++; if (pc0 !== exp_pc) begin bad++; $display("FAIL plain_pc c=%0d got=%0d exp=%0d", c, pc0, exp_pc); end
      end
      if (c == 5 || c == 10 || c == 15) done = 1'b1;
    end
    START = 1'b0;
  endtask

  task automatic test_mvi();
    apply_reset();
    PC_LOAD = 1'b1; PC_IN = 5'd4;
    tick();
    PC_LOAD = 1'b0;
    total++; if (pc0 !== 5'd4) begin bad++; $display("FAIL mvi_load got=%0d exp=4", pc0); end
    START = 1'b1;
    tick();                       // FETCH
    tick();                       // ISSUE
    total++; if (bus0.RUN !== 1'b1) begin bad++; $display("FAIL mvi_run got=%b exp=1", bus0.RUN); end
    total++; if (bus0.D_IN !== 9'h040) begin bad++; $display("FAIL mvi_opword got=%h exp=040", bus0.D_IN); end
    tick();                       // WAIT 1
    total++; if (bus0.D_IN !== 9'h0A5) begin bad++; $display("FAIL mvi_imm1 got=%h exp=0a5", bus0.D_IN); end
    total++; if (bus0.RUN !== 1'b0) begin bad++; $display("FAIL mvi_run_low got=%b exp=0", bus0.RUN); end
    tick();                       // WAIT 2
    total++; if (bus0.D_IN !== 9'h0A5) begin bad++; $display("FAIL mvi_imm2 got=%h exp=0a5", bus0.D_IN); end
    done = 1'b1;
    tick();                       // FETCH at 6
    done = 1'b0;
    total++; if (pc0 !== 5'd6) begin bad++; $display("FAIL mvi_pc got=%0d exp=6", pc0); end
    tick();                       // ISSUE of word 6
    total++; if (bus0.D_IN !== 9'h0C3 || bus0.RUN !== 1'b1) begin bad++; $display("FAIL mvi_next got=%h/%b exp=0c3/1", bus0.D_IN, bus0.RUN); end
    START = 1'b0;
  endtask

  task automatic test_end_of_program();
    apply_reset();
    PC_LOAD = 1'b1; PC_IN = 5'd31;
    tick();
    PC_LOAD = 1'b0;
    START = 1'b1;
    tick();                       // FETCH
    START = 1'b0;
    tick();                       // ISSUE
    total++; if (bus0.D_IN !== 9'h16C || bus1.D_IN !== 9'h16C) begin bad++; $display("FAIL eop_din got=%h/%h exp=16c", bus0.D_IN, bus1.D_IN); end
    tick();                       // WAIT
    done = 1'b1;
    tick();
    done = 1'b0;
    total++; if ({halt0, busy0} !== 2'b10) begin bad++; $display("FAIL eop_halt got=%b exp=10", {halt0, busy0}); end
    total++; if (pc0 !== 5'd0) begin bad++; $display("FAIL eop_pc got=%0d exp=0", pc0); end
    total++; if ({halt1, busy1} !== 2'b01) begin bad++; $display("FAIL wrap_busy got=%b exp=01", {halt1, busy1}); end
    total++; if (pc1 !== 5'd0) begin bad++; $display("FAIL wrap_pc got=%0d exp=0", pc1); end
    tick();
    total++; if (bus1.RUN !== 1'b1 || bus1.D_IN !== 9'h089) begin bad++; $display("FAIL wrap_issue got=%b/%h exp=1/089", bus1.RUN, bus1.D_IN); end
    total++; if (bus0.RUN !== 1'b0 || halt0 !== 1'b1) begin bad++; $display("FAIL eop_quiet got=%b/%b exp=0/1", bus0.RUN, halt0); end
  endtask

  task automatic test_stop();
    apply_reset();
    START = 1'b1;
    tick();                       // c1 FETCH
    START = 1'b0;
    tick();                       // c2 ISSUE
    tick();                       // c3 WAIT
    STOP = 1'b1;
    tick();                       // c4
    STOP = 1'b0;
    tick();                       // c5
    done = 1'b1;
    tick();                       // c6
    done = 1'b0;
    total++; if ({halt0, busy0} !== 2'b10) begin bad++; $display("FAIL stop_halt got=%b exp=10", {halt0, busy0}); end
    total++; if (pc0 !== 5'd1) begin bad++; $display("FAIL stop_pc got=%0d exp=1", pc0); end
    for (int c = 7; c <= 10; c++) begin
      tick();
      total++; if (bus0.RUN !== 1'b0 || halt0 !== 1'b1) begin bad++; $display("FAIL stop_quiet c=%0d got=%b/%b exp=0/1", c, bus0.RUN, halt0); end
    end
    START = 1'b1;
    tick();                       // c11 FETCH
    START = 1'b0;
    tick();                       // c12 ISSUE
    total++; if (bus0.RUN !== 1'b1 || bus0.D_IN !== 9'h0D2) begin bad++; $display("FAIL stop_resume got=%b/%h exp=1/0d2", bus0.RUN, bus0.D_IN); end
    tick();                       // c13 WAIT
    done = 1'b1;
    tick();                       // c14 FETCH, stop latch must be clear
    done = 1'b0;
    total++; if ({halt0, busy0} !== 2'b01 || pc0 !== 5'd2) begin bad++; $display("FAIL stop_cleared got=%b pc=%0d exp=01 pc=2", {halt0, busy0}, pc0); end
  endtask

  task automatic test_timeout();
    apply_reset();
    START = 1'b1;
    tick();                       // c1
    START = 1'b0;
    tick();                       // c2 ISSUE
    for (int c = 3; c <= 66; c++) begin
      tick();
      total++; if (err0 !== 1'b0) begin bad++; $display("FAIL wd_early c=%0d got=%b exp=0", c, err0); end
    end
    tick();                       // c67 = WAIT entry + TIMEOUT
    total++; if (err0 !== 1'b1) begin bad++; $display("FAIL wd_error got=%b exp=1", err0); end
    for (int c = 0; c < 8; c++) begin
      START = ~START;
      done  = START;
      tick();
      total++; if ({err0, busy0, bus0.RUN} !== 3'b100) begin bad++; $display("FAIL wd_sticky i=%0d got=%b exp=100", c, {err0, busy0, bus0.RUN}); end
    end
    START = 1'b0;
    done  = 1'b0;
  endtask

  task automatic test_reset_in_wait();
    apply_reset();
    PC_LOAD = 1'b1; PC_IN = 5'd4;
    tick();
    PC_LOAD = 1'b0;
    START = 1'b1;
    tick();                       // FETCH
    tick();                       // ISSUE
    START = 1'b0;
    tick();                       // WAIT, immediate on D_IN
    total++; if (bus0.D_IN !== 9'h0A5 || busy0 !== 1'b1) begin bad++; $display("FAIL rw_pre got=%h/%b exp=0a5/1", bus0.D_IN, busy0); end
    #2;
    RST = 1'b0;
    #1;
    total++; if (bus0.RUN !== 1'b0 || bus0.D_IN !== 9'h000) begin bad++; $display("FAIL rw_out got=%b/%h exp=0/000", bus0.RUN, bus0.D_IN); end
    total++; if (pc0 !== 5'd0 || busy0 !== 1'b0) begin bad++; $display("FAIL rw_state got=%0d/%b exp=0/0", pc0, busy0); end
    tick();
    RST  = 1'b1;
    done = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (c == 1) done = 1'b0;
      total++; if ({bus0.RUN, busy0, halt0} !== 3'b000 || pc0 !== 5'd0) begin bad++; $display("FAIL rw_late_done i=%0d got=%b pc=%0d exp=000 pc=0", c, {bus0.RUN, busy0, halt0}, pc0); end
    end
  endtask

  initial begin
    test_reset();
    test_plain();
    test_mvi();
    test_end_of_program();
    test_stop();
    test_timeout();
    test_reset_in_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
